ps2_tx: RTL and testbench

- Host-to-device PS/2 transmitter: sends one command byte (e.g. LED set 0xED, enable 0xF4) from the FPGA to a keyboard.
- Implements the full host request: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, and the device acknowledge.
- Drives the shared open-drain PS/2 clock and data lines through output-enable pins; the top level builds the tri-states.
- Runs alongside the PS/2 receiver on the same lines; the receiver output is ignored while o_busy=1.

---
 rtl/ps2_tx.sv | 152 +++++++++++++++
 tb/tb_ps2_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter (inhibit, request, 10 device-clocked bits, ack)
//
// Ports:
//   i_clk, i_rst_n   system clock, asynchronous active-low reset
//   i_data, i_send   byte to send and single-cycle send request (ignored while busy)
//   i_ps2_clk/data   PS/2 line levels as seen at the pins
//   o_ps2_clk_oe     1 = pull the clock line low
//   o_ps2_data_oe    1 = pull the data line low
//   o_busy           transfer in progress
//   o_done, o_err    one-cycle completion / failure pulses
module ps2_tx #(
    parameter int INHIBIT_CYC = 6000,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 750000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_send,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);
    localparam int CMAX = INHIBIT_CYC > TIMEOUT_CYC ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int FW   = $clog2(FILT_LEN + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

    state_t          state;
    logic [1:0]      clk_sync;
    logic [1:0]      dat_sync;
    logic [FW-1:0]   filt_cnt;
    logic            filt_clk;
    logic            filt_prev;
    logic [9:0]      frame;
    logic [3:0]      bit_cnt;
    logic [CW-1:0]   cnt;
    logic            fall;
    logic            dev_owned;
    logic            tmo;

    assign fall      = filt_prev & ~filt_clk;
    assign dev_owned = state == SEND || state == ACK || state == WAIT_IDLE;
    assign tmo       = dev_owned && !fall && cnt == CW'(TIMEOUT_CYC - 1);

    // Synchronizers idle high so a reset never fabricates a falling edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_sync  <= 2'b11;
            dat_sync  <= 2'b11;
            filt_cnt  <= '0;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], i_ps2_clk};
            dat_sync  <= {dat_sync[0], i_ps2_data};
            filt_prev <= filt_clk;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            frame         <= '0;
            bit_cnt       <= '0;
            cnt           <= '0;
            o_ps2_clk_oe  <= 1'b0;
            o_ps2_data_oe <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            // While the device owns the clock, cnt measures time since its last falling edge.
            if (dev_owned)
                cnt <= fall ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    // A request coinciding with a completion pulse is dropped.
                    if (i_send && !o_done && !o_err) begin
                        frame        <= {1'b1, ~^i_data, i_data};
                        bit_cnt      <= '0;
                        cnt          <= '0;
                        o_busy       <= 1'b1;
                        o_ps2_clk_oe <= 1'b1;
                        state        <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == CW'(INHIBIT_CYC - 1)) begin
                        cnt           <= '0;
                        o_ps2_data_oe <= 1'b1;
                        state         <= REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REQ: begin
                    o_ps2_clk_oe <= 1'b0;
                    cnt          <= '0;
                    state        <= SEND;
                end
                SEND: begin
                    if (fall) begin
                        o_ps2_data_oe <= ~frame[bit_cnt];
                        bit_cnt       <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd9)
                            state <= ACK;
                    end
                end
                ACK: begin
                    if (fall) begin
                        o_err  <= dat_sync[1];
                        o_busy <= ~dat_sync[1];
                        state  <= dat_sync[1] ? IDLE : WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (filt_clk && dat_sync[1]) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Timeout overrides whatever the state arm decided this cycle.
            if (tmo) begin
                o_done        <= 1'b0;
                o_err         <= 1'b1;
                o_busy        <= 1'b0;
                o_ps2_clk_oe  <= 1'b0;
                o_ps2_data_oe <= 1'b0;
                state         <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: randomized scoreboard bench for ps2_tx with a behavioural PS/2 device model
module tb_ps2_tx;
    localparam int INH  = 300;
    localparam int FL   = 8;
    localparam int TMO  = 2000;
    localparam int HALF = 50;
    localparam int M_NORM = 0, M_GLITCH = 1, M_ACK1 = 2, M_SILENT = 3, M_INJ = 4, M_RESET = 5;

    typedef struct {
        logic [7:0] d;
        bit         is_err;
        bit         timed;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       send = 1'b0;
    logic [7:0] data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk, ps2_data;
    logic       clk_oe, data_oe, busy, done, err;
    int         cyc = 0;
    int         rel_cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    exp_t       exp_q[$];
    logic [10:0] cap_q[$];
    exp_t       e;

    assign ps2_clk  = ~clk_oe & dev_clk;
    assign ps2_data = ~data_oe & dev_data;

    ps2_tx #(.INHIBIT_CYC(INH), .FILT_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_send(send),
        .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
        .o_ps2_clk_oe(clk_oe), .o_ps2_data_oe(data_oe),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every completion pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && (done || err)) begin
            chk("done_err_exclusive", done & err, 0);
            chk("busy_low_at_end", busy, 0);
            chk("pending_entry", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("result_is_err", err, e.is_err);
                if (e.timed) begin
                    chk("timeout_latency", cyc - rel_cyc, TMO);
                    chk("oe_after_timeout", {clk_oe, data_oe}, 0);
                end
                if (!e.is_err) begin
                    chk("frame_captured", cap_q.size() > 0, 1);
                    if (cap_q.size() > 0)
                        chk("frame_bits", cap_q.pop_front(), {1'b1, odd_par(e.d), e.d, 1'b0});
                end
            end
        end
    end

    // Device model: samples the data line while the clock is high, then generates a falling edge.
    task automatic device(input int mode);
        int n;
        logic [10:0] cap;
        cap = '0;
        n = 0;
        while (!clk_oe && n < 10) begin n++; @(negedge clk); end
        chk("inhibit_start", clk_oe, 1);
        n = 0;
        while (clk_oe && n < INH + 50) begin
            send = (mode == M_INJ && n == 10);
            if (send) data = 8'h3C;
            n++;
            @(negedge clk);
        end
        send = 1'b0;
        chk("clock_low_len", n, INH + 1);
        chk("start_bit_driven", data_oe, 1);
        rel_cyc = cyc;
        if (mode == M_SILENT) return;
        cyc_wait(20);
        for (int b = 0; b < 11; b++) begin
            cyc_wait(20);
            if (mode == M_GLITCH && b > 1 && b < 9) dev_clk = 1'b0;
            cyc_wait(3);
            dev_clk = 1'b1;
            cyc_wait(HALF - 23);
            cap[b] = ps2_data;
            if (b == 10 && mode != M_ACK1) dev_data = 1'b0;
            cyc_wait(5);
            dev_clk = 1'b0;
            if (mode == M_RESET && b == 4) begin
                cyc_wait(30);
                rst_n = 1'b0;
                #1;
                chk("rst_clk_oe", clk_oe, 0);
                chk("rst_data_oe", data_oe, 0);
                chk("rst_busy", busy, 0);
                chk("rst_pulses", {done, err}, 0);
                dev_clk = 1'b1;
                dev_data = 1'b1;
                cyc_wait(5);
                rst_n = 1'b1;
                return;
            end
            cyc_wait(HALF);
            dev_clk = 1'b1;
        end
        cyc_wait(HALF);
        dev_data = 1'b1;
        if (mode != M_ACK1) cap_q.push_back(cap);
    endtask

    task automatic run(input logic [7:0] d, input int mode);
        exp_t x;
        int n;
        x.d = d;
        x.is_err = (mode == M_SILENT || mode == M_ACK1);
        x.timed = (mode == M_SILENT);
        if (mode != M_RESET) exp_q.push_back(x);
        data = d;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        device(mode);
        n = 0;
        while (busy && n < TMO + 500) begin n++; @(negedge clk); end
        chk("busy_release", busy, 0);
        cyc_wait(8);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("idle_lines_released", {clk_oe, data_oe}, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", {clk_oe, data_oe, busy, done, err}, 0);
        cyc_wait(3);
        rst_n = 1'b1;
        cyc_wait(3);
        run(8'hED, M_NORM);
        run(8'hF4, M_NORM);
        run(8'h00, M_NORM);
        run(8'hAA, M_SILENT);
        run(8'h12, M_ACK1);
        run(8'hF4, M_NORM);
        run(8'h5A, M_INJ);
        run(8'hC3, M_GLITCH);
        run(8'hED, M_RESET);
        run(8'hED, M_NORM);
        for (int i = 0; i < 10; i++)
            run(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
        chk("final_queue_empty", exp_q.size() + cap_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end
endmodule
